tcam_search_ctrl: RTL and testbench

- Array-side controller driving a DEPTH x WIDTH array of reversible TCAM cells, and the opposite end of the cell's word-line, bit, search-line and match-line interface.
- Writes entries by pulsing one-hot word lines with bit data.
- Searches by precharging, then broadcasting a key on the search lines, sampling the match lines and priority-encoding the result.
- Sits between the host command path and the cell array; owns the per-entry valid bits.

---
 rtl/tcam_search_ctrl.sv | 173 +++++++++++++++++
 tb/tb_tcam_search_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_search_ctrl.sv
// Array-side controller for a DEPTH x WIDTH reversible TCAM array.
// Writes entries through one-hot word lines and searches by precharging the
// match lines, driving the key, then sampling and priority-encoding the hits.
// It owns the per-entry valid bits, so stale match lines never produce a hit.
module tcam_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [WIDTH-1:0] cmd_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic             rsp_multi,
  output logic [AW-1:0]    rsp_index,
  output logic [DEPTH-1:0] arr_wl,
  output logic [WIDTH-1:0] arr_bl,
  output logic [WIDTH-1:0] arr_sl,
  output logic             arr_pre,
  input  logic [DEPTH-1:0] arr_ml
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_INVAL  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    PRE,
    SEARCH,
    SAMPLE,
    RESP
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [1:0]       op_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] key_q;
  logic [DEPTH-1:0] valid_q;

  logic [DEPTH-1:0] wl_nx;
  logic [WIDTH-1:0] bl_nx;
  logic [WIDTH-1:0] sl_nx;
  logic             pre_nx;

  logic [DEPTH-1:0] hits;
  logic             hit_c;
  logic             multi_c;
  logic [AW-1:0]    idx_c;
  logic             found;

  assign cmd_ready = (state == IDLE);

  // State and settle-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Next state plus the next values of the registered array-side lines,
  // so each line is already correct in the first cycle of its state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    wl_nx    = '0;
    bl_nx    = '0;
    sl_nx    = '0;
    pre_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_SEARCH) begin
            state_nx = PRE;
            pre_nx   = 1'b1;
          end else begin
            state_nx = WRITE;
            if (cmd_op == OP_WRITE) begin
              wl_nx = {{(DEPTH-1){1'b0}}, 1'b1} << cmd_addr;
              bl_nx = cmd_key;
            end
          end
        end
      end
      WRITE: state_nx = IDLE;
      PRE: begin
        state_nx = SEARCH;
        cnt_nx   = '0;
        sl_nx    = key_q;
      end
      SEARCH: begin
        // Key stays on the search lines through SAMPLE as well.
        sl_nx = key_q;
        if (cnt_q == CW'(SETTLE - 1)) state_nx = SAMPLE;
        else cnt_nx = cnt_q + 1'b1;
      end
      SAMPLE: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Match evaluation: mask by valid, detect multiple hits, find lowest index.
  always_comb begin
    hits    = arr_ml & valid_q;
    hit_c   = |hits;
    multi_c = |(hits & (hits - 1'b1));
    idx_c   = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (hits[i] && !found) begin
        idx_c = AW'(i);
        found = 1'b1;
      end
    end
  end

  // Command capture, valid bits, array-side line registers and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      addr_q    <= '0;
      key_q     <= '0;
      valid_q   <= '0;
      arr_wl    <= '0;
      arr_bl    <= '0;
      arr_sl    <= '0;
      arr_pre   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_multi <= 1'b0;
      rsp_index <= '0;
    end else begin
      arr_wl  <= wl_nx;
      arr_bl  <= bl_nx;
      arr_sl  <= sl_nx;
      arr_pre <= pre_nx;
      if (state == IDLE && cmd_valid) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        key_q  <= cmd_key;
      end
      if (state == WRITE) begin
        if (op_q == OP_WRITE) valid_q[addr_q] <= 1'b1;
        else if (op_q == OP_INVAL) valid_q[addr_q] <= 1'b0;
      end
      if (state == SAMPLE) begin
        rsp_valid <= 1'b1;
        rsp_hit   <= hit_c;
        rsp_multi <= multi_c;
        rsp_index <= idx_c;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcam_search_ctrl.sv
// Scoreboard bench for tcam_search_ctrl: a driver issues commands and pushes
// expected search results computed from a simple valid-bit model; a monitor
// compares whenever a response is presented.
module tb_tcam_search_ctrl;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [A-1:0] cmd_addr;
  logic [W-1:0] cmd_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_hit;
  logic         rsp_multi;
  logic [A-1:0] rsp_index;
  logic [D-1:0] arr_wl;
  logic [W-1:0] arr_bl;
  logic [W-1:0] arr_sl;
  logic         arr_pre;
  logic [D-1:0] arr_ml;

  tcam_search_ctrl #(.WIDTH(W), .DEPTH(D), .AW(A), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_key(cmd_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_multi(rsp_multi), .rsp_index(rsp_index),
    .arr_wl(arr_wl), .arr_bl(arr_bl), .arr_sl(arr_sl), .arr_pre(arr_pre),
    .arr_ml(arr_ml)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         hit;
    logic         multi;
    logic [A-1:0] idx;
    int unsigned  cyc;
  } exp_t;

  exp_t         q[$];
  logic [D-1:0] mvalid;
  int           checks = 0;
  int           failures = 0;
  int unsigned  cyc = 0;
  int           rdy_mode = 0;
  logic         prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response-ready driver: random, forced low, or forced high.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: compares every presented response against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
        chk("ready_low_in_resp", {31'd0, cmd_ready}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          if (!prev_v) chk("rsp_latency", cyc, q[0].cyc);
          chk("rsp_hit", {31'd0, rsp_hit}, {31'd0, q[0].hit});
          chk("rsp_multi", {31'd0, rsp_multi}, {31'd0, q[0].multi});
          chk("rsp_index", {28'd0, rsp_index}, {28'd0, q[0].idx});
          if (rsp_ready) q.delete(0);
        end
      end
      prev_v = (rst_n === 1'b1) && (rsp_valid === 1'b1);
    end
  end

  task automatic do_cmd(input logic [1:0] op, input logic [A-1:0] addr,
                        input logic [W-1:0] key, input logic [D-1:0] ml);
    int n;
    exp_t e;
    logic [D-1:0] h;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_key   = key;
    arr_ml    = ml;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 100 cycles");
      cmd_valid = 1'b0;
      return;
    end
    if (op == 2'b01) begin
      h       = ml & mvalid;
      e.hit   = (h != '0);
      e.multi = ($countones(h) > 1);
      e.idx   = '0;
      for (int i = D - 1; i >= 0; i--) if (h[i]) e.idx = A'(i);
      e.cyc   = cyc + S + 3;
      q.push_back(e);
    end else if (op == 2'b00) begin
      mvalid[addr] = 1'b1;
    end else if (op == 2'b10) begin
      mvalid[addr] = 1'b0;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", {31'd0, cmd_ready}, 32'd0);
    case (op)
      2'b00: begin
        chk("write_wl", {16'd0, arr_wl}, 32'(16'd1 << addr));
        chk("write_bl", {24'd0, arr_bl}, {24'd0, key});
        @(negedge clk);
        chk("write_done_ready", {31'd0, cmd_ready}, 32'd1);
        chk("write_done_wl", {16'd0, arr_wl}, 32'd0);
      end
      2'b01: begin
        chk("pre_on", {31'd0, arr_pre}, 32'd1);
        chk("pre_sl", {24'd0, arr_sl}, 32'd0);
        for (int i = 0; i < S + 1; i++) begin
          @(negedge clk);
          chk("search_pre_off", {31'd0, arr_pre}, 32'd0);
          chk("search_sl", {24'd0, arr_sl}, {24'd0, key});
        end
      end
      default: begin
        chk("nowrite_wl", {16'd0, arr_wl}, 32'd0);
        @(negedge clk);
        chk("nowrite_done_ready", {31'd0, cmd_ready}, 32'd1);
      end
    endcase
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got %0d pending responses expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_key   = '0;
    arr_ml    = '0;
    mvalid    = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wl", {16'd0, arr_wl}, 32'd0);
    chk("rst_pre", {31'd0, arr_pre}, 32'd0);
    rst_n = 1'b1;

    // Empty table, a few writes, multi-hit, invalidate.
    do_cmd(2'b01, '0, 8'hA5, 16'($urandom));
    do_cmd(2'b00, 4'd3, 8'h5A, '0);
    do_cmd(2'b00, 4'd9, 8'hC3, '0);
    do_cmd(2'b01, '0, 8'h5A, 16'h0208);
    do_cmd(2'b10, 4'd3, 8'h00, '0);
    do_cmd(2'b01, '0, 8'h5A, 16'h0208);
    do_cmd(2'b11, 4'd9, 8'hFF, '0);
    do_cmd(2'b01, '0, 8'hC3, 16'hFFFF);
    wait_drain();

    // Held response with rsp_ready low.
    rdy_mode = 1;
    do_cmd(2'b01, '0, 8'h11, 16'h0200);
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("held_ready_low", {31'd0, cmd_ready}, 32'd0);
    chk("held_valid", {31'd0, rsp_valid}, 32'd1);
    rdy_mode = 2;
    wait_drain();
    @(negedge clk);
    chk("after_hs_ready", {31'd0, cmd_ready}, 32'd1);
    chk("after_hs_valid", {31'd0, rsp_valid}, 32'd0);
    rdy_mode = 0;

    // Reset in the middle of a search.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_key   = 8'h77;
    arr_ml    = '1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wl", {16'd0, arr_wl}, 32'd0);
    chk("midrst_bl", {24'd0, arr_bl}, 32'd0);
    chk("midrst_sl", {24'd0, arr_sl}, 32'd0);
    chk("midrst_pre", {31'd0, arr_pre}, 32'd0);
    chk("midrst_rsp", {28'd0, rsp_valid, rsp_hit, rsp_multi, 1'b0} | {28'd0, rsp_index}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    mvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_cmd(2'b01, '0, 8'h77, '1);
    wait_drain();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      do_cmd(2'($urandom_range(0, 3)), A'($urandom), W'($urandom), D'($urandom));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
